scan_mem_loader: RTL

Device-side responder for the serial scan-load protocol. The host shifts in an op bit, a 32-bit word count and a 32-bit start address, then streams data. The block deserialises this and either writes words into instruction/data memory, or reads words back and serialises them on scan_out. It sits between the scan pins and the memory write/read port, and holds the core via busy while active.

---
 rtl/scan_mem_loader.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/scan_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : scan_mem_loader
// Summary  : Serial scan-load responder. Deserialises an op bit, 32-bit length
//            and 32-bit start address, then writes streamed words to memory or
//            (with SCAN_READBACK_EN defined) reads words back onto scan_out.
// Revision : 1.0 - initial release
// ============================================================================
module scan_mem_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    localparam int             CNT_W       = (DATA_W > 32) ? $clog2(DATA_W) : 5;
    localparam logic [CNT_W-1:0] c_HDR_LAST  = CNT_W'(31);
    localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RGAP1 = 3'd4,
        S_RGAP2 = 3'd5,
        S_RDATA = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic                r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [30:0]         r_hdr;
    logic [31:0]         r_len;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_sh;
    logic                r_we;
    logic                r_done;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_wdata;
`ifdef SCAN_READBACK_EN
    logic                r_re;
    logic [DATA_W-1:0]   r_pf;
`endif

    logic [31:0]         w_hdr_word;
    logic [31:0]         w_len_dec;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_hdr_last;
    logic                w_data_last;
    logic                w_unused;

    // The final header bit is still on scan_in when the field completes.
    assign w_hdr_word  = {scan_in, r_hdr};
    assign w_len_dec   = r_len - 32'd1;
    assign w_addr_inc  = r_addr + ADDR_W'(4);
    assign w_hdr_last  = (r_cnt == c_HDR_LAST);
    assign w_data_last = (r_cnt == c_DATA_LAST);
    assign w_unused    = ^{mem_rdata, r_sh[0]};

    always_ff @(posedge clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (!scan_en) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nx = S_LEN;
                S_LEN:   if (w_hdr_last) w_state_nx = S_ADDR;
                S_ADDR: begin
                    if (w_hdr_last) begin
                        if (r_len == 32'd0)  w_state_nx = S_DONE;
                        else if (r_op)       w_state_nx = S_WDATA;
`ifdef SCAN_READBACK_EN
                        else                 w_state_nx = S_RGAP1;
`else
                        else                 w_state_nx = S_DONE;
`endif
                    end
                end
                S_WDATA: if (w_data_last && (r_len == 32'd1)) w_state_nx = S_DONE;
`ifdef SCAN_READBACK_EN
                S_RGAP1: w_state_nx = S_RGAP2;
                S_RGAP2: w_state_nx = S_RDATA;
                S_RDATA: if (w_data_last && (r_len == 32'd1)) w_state_nx = S_DONE;
`endif
                S_DONE:  w_state_nx = S_DONE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // A dropped scan_en is treated exactly like reset for the datapath.
    always_ff @(posedge clk) begin
        if (!Rst || !scan_en) begin
            r_op       <= 1'b0;
            r_cnt      <= '0;
            r_hdr      <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_sh       <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
`ifdef SCAN_READBACK_EN
            r_re       <= 1'b0;
            r_pf       <= '0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= (w_state_nx == S_DONE) && (r_state != S_DONE);
`ifdef SCAN_READBACK_EN
            r_re   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_op  <= scan_in;
                    r_cnt <= '0;
                end
                S_LEN: begin
                    r_hdr <= {scan_in, r_hdr[30:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_hdr_last) begin
                        r_len <= w_hdr_word;
                        r_cnt <= '0;
                    end
                end
                S_ADDR: begin
                    r_hdr <= {scan_in, r_hdr[30:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_hdr_last) begin
                        r_addr <= {w_hdr_word[ADDR_W-1:2], 2'b00};
                        r_cnt  <= '0;
`ifdef SCAN_READBACK_EN
                        if ((r_len != 32'd0) && !r_op) begin
                            r_re       <= 1'b1;
                            r_mem_addr <= {w_hdr_word[ADDR_W-1:2], 2'b00};
                        end
`endif
                    end
                end
                S_WDATA: begin
                    r_sh  <= {scan_in, r_sh[DATA_W-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_data_last) begin
                        r_we       <= 1'b1;
                        r_wdata    <= {scan_in, r_sh[DATA_W-1:1]};
                        r_mem_addr <= r_addr;
                        r_addr     <= w_addr_inc;
                        r_len      <= w_len_dec;
                        r_cnt      <= '0;
                    end
                end
`ifdef SCAN_READBACK_EN
                S_RGAP2: begin
                    r_sh  <= mem_rdata;
                    r_cnt <= '0;
                    if (r_len > 32'd1) begin
                        r_re       <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                    end
                end
                S_RDATA: begin
                    r_sh  <= r_sh >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Prefetch issued on bit 0 returns data during bit 1.
                    if (r_cnt == CNT_W'(1)) begin
                        r_pf <= mem_rdata;
                    end
                    if (w_data_last) begin
                        r_sh   <= r_pf;
                        r_cnt  <= '0;
                        r_addr <= w_addr_inc;
                        r_len  <= w_len_dec;
                        if (w_len_dec > 32'd1) begin
                            r_re       <= 1'b1;
                            r_mem_addr <= w_addr_inc + ADDR_W'(4);
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign mem_we    = r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_wdata;
`ifdef SCAN_READBACK_EN
    assign mem_re    = r_re;
    assign scan_out  = (r_state == S_RDATA) & r_sh[0];
`else
    assign mem_re    = 1'b0;
    assign scan_out  = 1'b0;
`endif

endmodule
`default_nettype wire
